mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-port arbiter that shares the single memory bus between the CPU and a DMA/loader port. The bus covers the 16-bit address space: RAM in the low region and ROM at `ROM_BASE` and above. The CPU has priority, and a starvation limit guarantees DMA progress. Each access is sequenced through a fixed issue/response FSM. Writes into the ROM region are blocked and flagged. The block sits inside `computer` between `u_cpu`, the DMA port, and the `u_ram`/`u_rom` address decode.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, address bus width.
- `DATA_WIDTH`, 8, data bus width.
- `ROM_BASE`, 16'hF000, lowest ROM address. Writes at or above it are blocked.
- `STARVE_LIMIT`, 4, maximum consecutive CPU grants while DMA is waiting. Range 1..15.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_WIDTH  CPU address.
- `cpu_wdata`  in  DATA_WIDTH  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_WIDTH  read data, valid only while `cpu_ack`=1.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_ack`, `dma_rdata`  same as the CPU port, for DMA.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_rdata`  in  DATA_WIDTH  synchronous memory read data, valid the cycle after `mem_en`.
- `rom_wr_err`  out  1  one-cycle pulse on a blocked ROM-region write.
- `grant_dma`  out  1  current or last owner: 0 = CPU, 1 = DMA. For debug and the bench.

## Operation
- FSM states are IDLE, ISSUE, and RESP. There is no pipelining: at most one access is in flight.
- **IDLE:**
  - If neither request is high, stay in IDLE.
  - Otherwise select an owner, latch its `we`/`addr`/`wdata` into internal registers, and go to ISSUE.
- **Selection rule:**
  - Only `cpu_req` high: CPU.
  - Only `dma_req` high: DMA.
  - Both high: DMA if `starve_cnt == STARVE_LIMIT`, else CPU.
- **Starvation counter:** `starve_cnt` is 4 bits and saturates at `STARVE_LIMIT`.
  - On a CPU grant with `dma_req`=1: increment.
  - On a CPU grant with `dma_req`=0: clear to 0.
  - On a DMA grant: clear to 0.
- **ISSUE:**
  - `mem_addr`, `mem_wdata`, and `mem_we` are driven from the latched fields. `mem_en`=1.
  - Blocked write (latched `we`=1 and addr >= `ROM_BASE`): `mem_en`=0 and `mem_we`=0.
  - Always go to RESP.
- **RESP:**
  - Pulse the owner's `ack`.
  - Owner `rdata` = `mem_rdata` for a read, 0 for a write.
  - A blocked write pulses `rom_wr_err` and still acks.
  - Always go to IDLE.
- **Requester rules:**
  - Requests must stay stable from assertion to ack.
  - A `req` still high in the IDLE cycle after ack is treated as a new transaction.
  - Only the latched fields drive the bus, so request changes after grant have no effect.
- **Non-owner port:** `ack`=0 and `rdata`=0 at all times.
- **Outputs when not in ISSUE:** `mem_en`, `mem_we`, `mem_addr`, and `mem_wdata` are 0.

## Timing
- Reset values: state IDLE, `starve_cnt` 0, `grant_dma` 0, and every output 0.
- Latency, request seen high in IDLE at cycle N:
  - N+1: ISSUE, `mem_en`=1.
  - N+2: RESP, `ack`=1 and `rdata` valid.
  - N+3: IDLE.
- Throughput is one access per 3 cycles. A continuously held request is re-granted every 3 cycles.
- A request arriving while busy waits. It is evaluated in the next IDLE cycle, so worst-case CPU wait is 3 cycles.
- Worst-case DMA wait with the CPU saturating is `STARVE_LIMIT`×3 + 3 cycles.
- Reset asserted in ISSUE or RESP:
  - The FSM returns to IDLE on that edge.
  - No `ack` and no `rom_wr_err` are produced.
  - The interrupted write may or may not have reached memory; requesters discard it.
- Write at `ROM_BASE`-1 (16'hEFFF): allowed. Write at `ROM_BASE` (16'hF000): blocked.
- A read at or above `ROM_BASE` is always allowed.

## Test plan
- **CPU read:** preload RAM[0x0010]=0xAA; CPU read 0x0010.
  - `mem_en` high exactly at N+1.
  - `cpu_ack` at N+2 with `cpu_rdata`=0xAA.
  - `dma_ack` stays 0.
- **ROM write protect:** CPU write 0x55 to 0xF005.
  - `mem_en` stays 0.
  - `cpu_ack` and `rom_wr_err` pulse together at N+2.
  - ROM[0xF005] is unchanged.
  - A write of 0x55 to 0xEFFF completes with no error, and RAM then reads back 0x55.
- **Simultaneous requests:** CPU and DMA assert in the same cycle with `starve_cnt`=0.
  - CPU is acked first.
  - DMA is acked 3 cycles later.
  - `grant_dma` toggles 0→1.
- **Starvation:** CPU `req` held high continuously, DMA `req` held high, `STARVE_LIMIT`=4.
  - Grant order is exactly CPU, CPU, CPU, CPU, DMA, CPU…
  - `starve_cnt` returns to 0 after the DMA grant.
- **Back-to-back DMA:** DMA writes 0x11, 0x22, 0x33 to 0x0100–0x0102 with no CPU traffic.
  - Acks arrive 3 cycles apart.
  - Readback yields 0x11, 0x22, 0x33.
- **Reset mid-operation:** assert `reset` in ISSUE of a DMA read.
  - No `dma_ack` is produced.
  - All outputs are 0 on the next cycle.
  - A fresh CPU read after reset completes with normal N+2 latency.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - CPU/DMA memory bus arbiter with starvation limit and ROM write blocking
// One access in flight at a time, sequenced IDLE -> ISSUE -> RESP.
module mem_bus_arbiter #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] ROM_BASE     = 16'hF000,
  parameter int                    STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rom_wr_err,
  output logic                  grant_dma
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [3:0]            starve_cnt;
  logic                  owner;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  pick_dma;
  logic                  blocked;
  logic                  any_req;

  assign any_req  = cpu_req | dma_req;
  // DMA wins a tie only once the CPU has used up its run of consecutive grants.
  assign pick_dma = dma_req & (~cpu_req | (starve_cnt == LIMIT));
  assign blocked  = lat_we & (lat_addr >= ROM_BASE);
  assign grant_dma = owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      owner      <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if (state == IDLE && any_req) begin
      owner     <= pick_dma;
      lat_we    <= pick_dma ? dma_we    : cpu_we;
      lat_addr  <= pick_dma ? dma_addr  : cpu_addr;
      lat_wdata <= pick_dma ? dma_wdata : cpu_wdata;
      if (pick_dma || !dma_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_ack    = 1'b0;
    cpu_rdata  = '0;
    dma_ack    = 1'b0;
    dma_rdata  = '0;
    rom_wr_err = 1'b0;
    case (state)
      ISSUE: begin
        mem_en    = ~blocked;
        mem_we    = lat_we & ~blocked;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
      end
      RESP: begin
        rom_wr_err = blocked;
        if (owner) begin
          dma_ack   = 1'b1;
          dma_rdata = lat_we ? '0 : mem_rdata;
        end else begin
          cpu_ack   = 1'b1;
          cpu_rdata = lat_we ? '0 : mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed bench for mem_bus_arbiter with a behavioural memory
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        rom_wr_err, grant_dma;

  logic [7:0]  mem [0:65535];
  logic [7:0]  b2b [3];
  int          checks;
  int          errors;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rom_wr_err(rom_wr_err), .grant_dma(grant_dma)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory; reset reloads the few locations the bench reads before writing.
  always @(posedge clk) begin
    if (reset) begin
      mem[16'h0010] <= 8'hAA;
      mem[16'h0011] <= 8'hBB;
      mem[16'hF005] <= 8'h77;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    b2b[0] = 8'h11; b2b[1] = 8'h22; b2b[2] = 8'h33;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    reset = 1;
    tick; tick;
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_dma_ack", 32'(dma_ack), 0);
    chk("rst_grant", 32'(grant_dma), 0);
    chk("rst_err", 32'(rom_wr_err), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    reset = 0;

    // CPU read of preloaded RAM
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    chk("rd_n_en", 32'(mem_en), 0);
    tick;
    chk("rd_n1_en", 32'(mem_en), 1);
    chk("rd_n1_addr", 32'(mem_addr), 'h0010);
    chk("rd_n1_we", 32'(mem_we), 0);
    tick;
    chk("rd_n2_ack", 32'(cpu_ack), 1);
    chk("rd_n2_rdata", 32'(cpu_rdata), 'hAA);
    chk("rd_n2_dma_ack", 32'(dma_ack), 0);
    chk("rd_n2_en", 32'(mem_en), 0);
    cpu_req = 0;
    tick;
    chk("rd_n3_ack", 32'(cpu_ack), 0);

    // Blocked ROM write, then boundary write just below ROM
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'hF005; cpu_wdata = 8'h55;
    tick;
    chk("rom_n1_en", 32'(mem_en), 0);
    chk("rom_n1_we", 32'(mem_we), 0);
    tick;
    chk("rom_n2_ack", 32'(cpu_ack), 1);
    chk("rom_n2_err", 32'(rom_wr_err), 1);
    chk("rom_n2_rdata", 32'(cpu_rdata), 0);
    cpu_req = 0;
    tick;
    chk("rom_n3_err", 32'(rom_wr_err), 0);
    chk("rom_unchanged", 32'(mem[16'hF005]), 'h77);
    cpu_req = 1; cpu_addr = 16'hEFFF;
    tick;
    chk("efff_n1_en", 32'(mem_en), 1);
    chk("efff_n1_we", 32'(mem_we), 1);
    chk("efff_n1_wdata", 32'(mem_wdata), 'h55);
    tick;
    chk("efff_n2_ack", 32'(cpu_ack), 1);
    chk("efff_n2_err", 32'(rom_wr_err), 0);
    cpu_req = 0;
    tick;
    cpu_req = 1; cpu_we = 0;
    tick; tick;
    chk("efff_rb_ack", 32'(cpu_ack), 1);
    chk("efff_rb_data", 32'(cpu_rdata), 'h55);
    cpu_req = 0;
    tick;

    // Simultaneous requests with an empty starvation count
    cpu_req = 1; cpu_addr = 16'h0010;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0011;
    tick;
    chk("sim_n1_grant", 32'(grant_dma), 0);
    tick;
    chk("sim_n2_cpu_ack", 32'(cpu_ack), 1);
    chk("sim_n2_dma_ack", 32'(dma_ack), 0);
    chk("sim_n2_dma_rdata", 32'(dma_rdata), 0);
    cpu_req = 0;
    tick; tick;
    chk("sim_n4_grant", 32'(grant_dma), 1);
    tick;
    chk("sim_n5_dma_ack", 32'(dma_ack), 1);
    chk("sim_n5_dma_rdata", 32'(dma_rdata), 'hBB);
    chk("sim_n5_cpu_ack", 32'(cpu_ack), 0);
    chk("sim_n5_cpu_rdata", 32'(cpu_rdata), 0);
    dma_req = 0;
    tick;

    // Starvation: both held, expect CPU x4 then DMA then CPU
    cpu_req = 1; dma_req = 1;
    tick;
    for (int g = 0; g < 6; g++) begin
      tick;
      chk($sformatf("starve_cpu_ack_%0d", g), 32'(cpu_ack), (g == 4) ? 0 : 1);
      chk($sformatf("starve_dma_ack_%0d", g), 32'(dma_ack), (g == 4) ? 1 : 0);
      if (g == 3) chk("starve_cnt_full", 32'(dut.starve_cnt), 4);
      if (g == 4) chk("starve_cnt_clear", 32'(dut.starve_cnt), 0);
      if (g == 5) begin
        cpu_req = 0; dma_req = 0;
      end
      tick; tick;
    end

    // Back-to-back DMA writes, acks three cycles apart
    dma_req = 1; dma_we = 1; dma_addr = 16'h0100; dma_wdata = 8'h11;
    for (int k = 0; k < 3; k++) begin
      tick; tick;
      chk($sformatf("b2b_ack_%0d", k), 32'(dma_ack), 1);
      if (k < 2) begin
        dma_addr = 16'h0101 + 16'(k);
        dma_wdata = b2b[k+1];
      end else begin
        dma_req = 0;
      end
      tick;
      chk($sformatf("b2b_gap_%0d", k), 32'(dma_ack), 0);
    end
    for (int k = 0; k < 3; k++) begin
      dma_req = 1; dma_we = 0; dma_addr = 16'h0100 + 16'(k);
      tick; tick;
      chk($sformatf("b2b_rb_%0d", k), 32'(dma_rdata), 32'(b2b[k]));
      dma_req = 0;
      tick;
    end

    // Reset during ISSUE of a DMA read
    dma_req = 1; dma_we = 0; dma_addr = 16'h0011;
    tick;
    chk("rmid_issue_en", 32'(mem_en), 1);
    reset = 1; dma_req = 0;
    tick;
    chk("rmid_dma_ack", 32'(dma_ack), 0);
    chk("rmid_dma_rdata", 32'(dma_rdata), 0);
    chk("rmid_en", 32'(mem_en), 0);
    chk("rmid_grant", 32'(grant_dma), 0);
    chk("rmid_err", 32'(rom_wr_err), 0);
    chk("rmid_addr", 32'(mem_addr), 0);
    reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    tick;
    chk("post_rst_n1_en", 32'(mem_en), 1);
    tick;
    chk("post_rst_n2_ack", 32'(cpu_ack), 1);
    chk("post_rst_n2_rdata", 32'(cpu_rdata), 'hAA);
    cpu_req = 0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
